// File: rtl/tristate_bus_driver_pkg.sv
// Shared types and sizing helpers for the tristate bus driver and its arbiter.
// Optional bus keeper is enabled by defining BUS_KEEPER_EN.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } bus_state_e;

  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_TURN_CYCLES = 1;
  localparam int DEF_MAX_HOLD    = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/tristate_bus_driver_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping from the highest channel back to channel 0.
module rr_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int  CHANNELS = DEF_CHANNELS,
  localparam int IW       = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IW-1:0]       pointer,
  output logic [CHANNELS-1:0] winner_oh,
  output logic [IW-1:0]       winner_idx,
  output logic                valid
);

  int cand;

  always_comb begin
    winner_idx = '0;
    valid      = 1'b0;
    cand       = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = (int'(pointer) + i) % CHANNELS;
      if (!valid && req[cand]) begin
        valid      = 1'b1;
        winner_idx = IW'(cand);
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_onehot
    assign winner_oh[gi] = valid && (winner_idx == IW'(gi));
  end

endmodule

// File: rtl/tristate_bus_driver.sv
// Round-robin owner of a shared tristate bus with turnaround gaps and bounded hold.
// Define BUS_KEEPER_EN to weakly hold the last driven value while the bus is released.
module tristate_bus_driver
  import tristate_bus_pkg::*;
#(
  parameter int  CHANNELS    = DEF_CHANNELS,
  parameter int  WIDTH       = DEF_WIDTH,
  parameter int  TURN_CYCLES = DEF_TURN_CYCLES,
  parameter int  MAX_HOLD    = DEF_MAX_HOLD,
  localparam int IW          = idx_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic [CHANNELS-1:0]       grant,
  output logic [IW-1:0]             owner,
  output logic                      enable,
  inout  wire  [WIDTH-1:0]          bus
);

  localparam int HW = cnt_width(MAX_HOLD);
  localparam int TW = cnt_width(TURN_CYCLES);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LOAD  = TW'(TURN_CYCLES);
  localparam logic [IW-1:0] LAST_IDX   = IW'(CHANNELS - 1);

  bus_state_e          state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [TW-1:0]       turn_q, turn_d;

  logic [CHANNELS-1:0] arb_oh;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;
  logic                owner_req;
  logic                others_req;
  logic                forced;

  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic [WIDTH-1:0]    drive_val;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign chan_data[gi] = data[gi*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req        (req),
    .pointer    (ptr_q),
    .winner_oh  (arb_oh),
    .winner_idx (arb_idx),
    .valid      (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    owner_req  = req[owner_q];
    others_req = |(req & ~grant_q);
    forced     = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT) && others_req;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = DRIVE;
          grant_d = arb_oh;
          owner_d = arb_idx;
          hold_d  = HW'(1);
          ptr_d   = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
        end
      end
      DRIVE: begin
        // A voluntary drop and a forced release on the same edge collapse into one release.
        if (!owner_req || forced) begin
          grant_d = '0;
          hold_d  = '0;
          if (TURN_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = TURN;
            turn_d  = TURN_LOAD;
          end
        end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LIMIT)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      TURN: begin
        if (turn_q <= TW'(1)) begin
          state_d = IDLE;
          turn_d  = '0;
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign enable    = (state_q == DRIVE);
  assign drive_val = chan_data[owner_q];

`ifdef BUS_KEEPER_EN
  logic [WIDTH-1:0] keep_q, keep_d;

  always_comb begin
    keep_d = keep_q;
    if (enable) begin
      keep_d = drive_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keep_q <= '0;
    end else begin
      keep_q <= keep_d;
    end
  end

  // The weak keeper loses to any strong driver, including this block's own.
  assign bus = enable ? drive_val : {WIDTH{1'bz}};
  assign (weak0, weak1) bus = enable ? {WIDTH{1'bz}} : keep_q;
`else
  assign bus = enable ? drive_val : {WIDTH{1'bz}};
`endif

endmodule
